// File: rtl/hdmi_qsys_frame_reader.sv
// Avalon-MM frame fetcher feeding an Avalon-ST pixel stream through a credit-limited FIFO.
// Define FRAME_LOOP_EN to make scanout repeat continuously instead of stopping after one frame.
module hdmi_qsys_frame_reader #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FRAME_WORDS  = 76800,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_sop,
  output logic                src_eop
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                    cs_q, cs_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];

  logic        push, pop, last_out, eop_pop;
  int unsigned credit;

  assign push     = pipe_q[READ_LATENCY-1];
  assign src_valid = (fcnt_q != '0);
  assign pop      = src_valid && src_ready;
  assign last_out = (out_cnt_q == CNT_W'(FRAME_WORDS - 1));
  assign eop_pop  = pop && last_out;

  assign src_data       = fifo_mem[rd_ptr_q];
  assign src_sop        = src_valid && (out_cnt_q == '0);
  assign src_eop        = src_valid && last_out;
  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write      = 1'b0;
  assign avm_byteenable = '1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    fcnt_d      = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
    pipe_d      = (pipe_q << 1) | READ_LATENCY'(cs_q);

    if (cs_q) begin
      addr_d      = addr_q + ADDR_W'(1);
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end
    if (pop) out_cnt_d = out_cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          addr_d      = base_addr;
          issue_cnt_d = '0;
          out_cnt_d   = '0;
          busy_d      = 1'b1;
        end
      end
      FETCH: begin
        if (cs_q && (issue_cnt_q == CNT_W'(FRAME_WORDS - 1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (eop_pop) begin
          done_d = 1'b1;
`ifdef FRAME_LOOP_EN
          state_d     = FETCH;
          addr_d      = base_addr;
          issue_cnt_d = '0;
          out_cnt_d   = '0;
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // chipselect is registered, so the credit test looks at next-cycle occupancy,
    // counting the read issued this cycle as already in flight.
    credit = 32'(fcnt_d) + 32'($countones(pipe_d));
    cs_d   = (state_d == FETCH) && (credit < FIFO_DEPTH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      cs_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pipe_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      cs_q        <= cs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pipe_q      <= pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= avm_readdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (fcnt_q == FCNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_hdmi_qsys_frame_reader.sv
// Directed bench for hdmi_qsys_frame_reader: four instances with different frame lengths,
// each read from a memory model whose word at address a holds the value a.
module tb_hdmi_qsys_frame_reader;

  localparam int unsigned NDUT = 4;

  function automatic int unsigned fw_of(input int unsigned g);
    case (g)
      0:       return 8;
      1:       return 4;
      2:       return 40;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [NDUT];
  logic        start     [NDUT];
  logic [16:0] base      [NDUT];
  logic        busy      [NDUT];
  logic        done      [NDUT];
  logic [16:0] addr      [NDUT];
  logic        cs        [NDUT];
  logic        wr        [NDUT];
  logic [3:0]  be        [NDUT];
  logic [31:0] rdata     [NDUT];
  logic [31:0] sdata     [NDUT];
  logic        src_valid [NDUT];
  logic        src_ready [NDUT];
  logic        src_sop   [NDUT];
  logic        src_eop   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    hdmi_qsys_frame_reader #(.FRAME_WORDS(fw_of(g))) u_dut (
      .clk(clk), .reset_n(rst_n[g]), .start(start[g]), .base_addr(base[g]),
      .busy(busy[g]), .done(done[g]), .avm_address(addr[g]), .avm_chipselect(cs[g]),
      .avm_write(wr[g]), .avm_byteenable(be[g]), .avm_readdata(rdata[g]),
      .src_data(sdata[g]), .src_valid(src_valid[g]), .src_ready(src_ready[g]),
      .src_sop(src_sop[g]), .src_eop(src_eop[g])
    );
  end

  // One-cycle-latency memory; non-read cycles return a poison value.
  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) rdata[k] <= cs[k] ? 32'(addr[k]) : 32'hDEADBEEF;
  end

  logic [33:0] got_q [NDUT][$];
  logic [16:0] iss1_q [$];
  int unsigned done_cnt [NDUT] = '{default: 0};
  int unsigned iss2 = 0, pop2 = 0, max_out2 = 0;

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (src_valid[k] && src_ready[k]) got_q[k].push_back({src_sop[k], src_eop[k], sdata[k]});
      if (done[k]) done_cnt[k]++;
    end
    if (cs[1]) iss1_q.push_back(addr[1]);
    iss2 += 32'(cs[2]);
    if (iss2 - pop2 > max_out2) max_out2 = iss2 - pop2;
    if (src_valid[2] && src_ready[2]) pop2++;
  end

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k, input logic [16:0] b);
    base[k]  = b;
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  // Cycle 0 is the start cycle; the caller has just left it.
  task automatic run_until_done(input int k, input int unsigned limit, input bit throttle,
                                input int unsigned poke_cyc, output int unsigned first_v,
                                output int unsigned done_c);
    int unsigned c;
    c = 1;
    first_v = 0;
    done_c = 0;
    while (c <= limit) begin
      start[k] = (c == poke_cyc);
      if (throttle) src_ready[k] = (c % 4 == 1);
      @(negedge clk);
      if (src_valid[k] && first_v == 0) first_v = c;
      if (done[k]) begin
        done_c = c;
        break;
      end
      tick();
      c++;
    end
    tick();
    start[k] = 1'b0;
    src_ready[k] = 1'b1;
  endtask

  task automatic check_frame(input int k, input int unsigned m, input int unsigned b,
                             input int unsigned n, input string tag);
    int unsigned avail;
    logic [33:0] exp_w;
    avail = unsigned'(got_q[k].size()) - m;
    chk({tag, "_word_count"}, 64'(avail), 64'(n));
    for (int unsigned i = 0; i < n && i < avail; i++) begin
      exp_w = {i == 0, i == n - 1, (b + i) & 32'h1FFFF};
      chk($sformatf("%s_word%0d", tag, i), 64'(got_q[k][m + i]), 64'(exp_w));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned m, d, mi, fv, dc;
    for (int k = 0; k < NDUT; k++) begin
      rst_n[k] = 1'b0; start[k] = 1'b0; src_ready[k] = 1'b1; base[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("reset_state%0d", k),
          64'({busy[k], done[k], cs[k], addr[k], src_valid[k], src_sop[k], src_eop[k]}), 64'(0));
    chk("const_write_be", 64'({wr[0], be[0]}), 64'(5'b01111));
    for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b1;
    tick();

    // Full-rate frame of 8 words at 0x100
    m = got_q[0].size(); d = done_cnt[0];
    pulse_start(0, 17'h00100);
    chk("t1_busy", 64'(busy[0]), 64'(1));
    run_until_done(0, 60, 1'b0, 0, fv, dc);
    chk("t1_first_valid_cycle", 64'(fv), 64'(3));
    chk("t1_done_cycle", 64'(dc), 64'(11));
    check_frame(0, m, 32'h100, 8, "t1");
    chk("t1_done_pulses", 64'(done_cnt[0] - d), 64'(1));
    chk("t1_busy_after", 64'({busy[0], cs[0]}), 64'(0));

    // Second start while busy, with a different base, must be ignored
    m = got_q[0].size(); d = done_cnt[0];
    pulse_start(0, 17'h00100);
    base[0] = 17'h05000;
    run_until_done(0, 60, 1'b0, 3, fv, dc);
    repeat (15) tick();
    check_frame(0, m, 32'h100, 8, "t4");
    chk("t4_done_pulses", 64'(done_cnt[0] - d), 64'(1));
    chk("t4_busy_after", 64'(busy[0]), 64'(0));

    // Reset after three words popped, then a clean frame
    m = got_q[0].size(); d = done_cnt[0];
    pulse_start(0, 17'h00100);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (got_q[0].size() - m >= 3) break;
    end
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    #1;
    chk("t5_reset_outputs",
        64'({busy[0], done[0], cs[0], addr[0], src_valid[0], src_sop[0], src_eop[0]}), 64'(0));
    repeat (4) tick();
    chk("t5_words_before_reset", 64'(unsigned'(got_q[0].size()) - m), 64'(3));
    chk("t5_no_done", 64'(done_cnt[0] - d), 64'(0));
    rst_n[0] = 1'b1;
    tick();
    m = got_q[0].size();
    pulse_start(0, 17'h00200);
    run_until_done(0, 60, 1'b0, 0, fv, dc);
    chk("t5_done_seen", 64'(dc != 0), 64'(1));
    check_frame(0, m, 32'h200, 8, "t5");

    // Address wrap at the top of the 17-bit space
    mi = iss1_q.size(); m = got_q[1].size();
    pulse_start(1, 17'h1FFFE);
    run_until_done(1, 40, 1'b0, 0, fv, dc);
    chk("t3_done_seen", 64'(dc != 0), 64'(1));
    chk("t3_issue_count", 64'(unsigned'(iss1_q.size()) - mi), 64'(4));
    for (int unsigned i = 0; i < 4 && mi + i < iss1_q.size(); i++)
      chk($sformatf("t3_addr%0d", i), 64'(iss1_q[mi + i]), 64'((32'h1FFFE + i) & 32'h1FFFF));
    check_frame(1, m, 32'h1FFFE, 4, "t3");

    // Sink ready 1 cycle in 4 on a 40-word frame: credit limit must be reached, never exceeded
    m = got_q[2].size(); d = done_cnt[2];
    pulse_start(2, 17'h00300);
    run_until_done(2, 400, 1'b1, 0, fv, dc);
    chk("t2_done_seen", 64'(dc != 0), 64'(1));
    check_frame(2, m, 32'h300, 40, "t2");
    chk("t2_max_outstanding", 64'(max_out2), 64'(16));
    chk("t2_done_pulses", 64'(done_cnt[2] - d), 64'(1));

    // Single-word frame: SOP and EOP on the same word
    m = got_q[3].size(); d = done_cnt[3];
    pulse_start(3, 17'h00042);
    run_until_done(3, 30, 1'b0, 0, fv, dc);
    chk("t6_first_valid_cycle", 64'(fv), 64'(3));
    chk("t6_done_cycle", 64'(dc), 64'(4));
    check_frame(3, m, 32'h42, 1, "t6");
    chk("t6_done_pulses", 64'(done_cnt[3] - d), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
